// File: rtl/fft_sdf_seq_ctrl.sv
// rtl/fft_sdf_seq_ctrl.sv - handshake-driven sequencer for a radix-2 SDF FFT pipeline
//
// Purpose: replaces free-running mux/twiddle counters with a controller that
// advances the datapath only on accepted samples. It then drains the pipe
// after the final frame.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   sample handshake; in_ready is never a function of in_valid
//   pipe_en               global clock-enable for every datapath delay register
//   in_zero               stage-0 input forced to zero while draining
//   mux_sel[s*MUXC_W+:]   00 butterfly sum, 01 delayed twiddled diff, 10 zero
//   w_idx[s*WIDX_W+:]     twiddle exponent k of W_N^k for stage s
//   out_valid, out_first  real output bin this cycle / bin 0 of a frame
//   frame_cnt             completed output frames (FFT_SEQ_FRAME_CNT_EN only)
//   busy                  controller not idle
//
// Build option: define FFT_SEQ_FRAME_CNT_EN to add the frame_cnt output.
module fft_sdf_seq_ctrl #(
  parameter int LOG2N  = 2,
  parameter int MUXC_W = 2,
  parameter int WIDX_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      pipe_en,
  output logic                      in_zero,
  output logic [LOG2N*MUXC_W-1:0]   mux_sel,
  output logic [LOG2N*WIDX_W-1:0]   w_idx,
  output logic                      out_valid,
  output logic                      out_first,
`ifdef FFT_SEQ_FRAME_CNT_EN
  output logic [15:0]               frame_cnt,
`endif
  output logic                      busy
);

  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] CNT_LAST  = LOG2N'(N - 1);
  localparam logic [LOG2N-1:0] CNT_PENUL = LOG2N'(N - 2);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state, state_d;
  logic [LOG2N-1:0] cnt, cnt_d;
  logic [LOG2N-1:0] fill, fill_d;
  logic [LOG2N-1:0] drain_cnt, drain_d;
  // Low while reset is held and on the first edge after release, so in_ready
  // reads 0 during reset even though the state register already says IDLE.
  logic             armed;
  logic             stage_on;
  logic [LOG2N-1:0] k;
  logic [WIDX_W-1:0] kw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      fill      <= '0;
      drain_cnt <= '0;
      armed     <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      fill      <= fill_d;
      drain_cnt <= drain_d;
      armed     <= 1'b1;
    end
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    fill_d   = fill;
    drain_d  = drain_cnt;
    in_ready = armed && (state != DRAIN);
    pipe_en  = 1'b0;
    in_zero  = 1'b0;
    busy     = (state != IDLE);
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          pipe_en = 1'b1;
          cnt_d   = cnt + 1'b1;
          fill_d  = (fill == CNT_LAST) ? fill : fill + 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (in_valid) begin
          pipe_en = 1'b1;
          cnt_d   = cnt + 1'b1;
          fill_d  = (fill == CNT_LAST) ? fill : fill + 1'b1;
        end else if (cnt == '0) begin
          // A gap right at a frame boundary means the stream has ended.
          state_d = DRAIN;
          drain_d = '0;
        end
      end
      DRAIN: begin
        pipe_en = 1'b1;
        in_zero = 1'b1;
        cnt_d   = cnt + 1'b1;
        if (drain_cnt == CNT_PENUL) begin
          state_d = IDLE;
          cnt_d   = '0;
          fill_d  = '0;
          drain_d = '0;
        end else begin
          drain_d = drain_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_valid = pipe_en && (fill == CNT_LAST);
  assign out_first = out_valid && (cnt == CNT_LAST);

  // Stage selects follow cnt in RUN/DRAIN; in IDLE they also follow cnt on the
  // cycle that accepts sample 0 so it is routed into the stage-0 delay line.
  assign stage_on = (state != IDLE) || pipe_en;

  always_comb begin
    mux_sel = '0;
    w_idx   = '0;
    k       = '0;
    kw      = '0;
    for (int s = 0; s < LOG2N; s++) begin
      // Stage s sees sample 0 of a frame N - N/2^s advances after stage 0.
      k  = cnt - LOG2N'(N - (N >> s));
      kw = WIDX_W'(k) & WIDX_W'((1 << (LOG2N - 1 - s)) - 1);
      if (!stage_on) begin
        mux_sel[s*MUXC_W +: MUXC_W] = MUXC_W'(2);
        w_idx[s*WIDX_W +: WIDX_W]   = '0;
      end else if (k[LOG2N-1-s]) begin
        mux_sel[s*MUXC_W +: MUXC_W] = MUXC_W'(0);
        w_idx[s*WIDX_W +: WIDX_W]   = kw << s;
      end else begin
        mux_sel[s*MUXC_W +: MUXC_W] = MUXC_W'(1);
        w_idx[s*WIDX_W +: WIDX_W]   = '0;
      end
    end
  end

`ifdef FFT_SEQ_FRAME_CNT_EN
  // The bin emitted at cnt == N-2 is the last bin of its frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (out_valid && (cnt == CNT_PENUL)) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fft_sdf_seq_ctrl.sv
// tb/tb_fft_sdf_seq_ctrl.sv - directed self-checking bench for fft_sdf_seq_ctrl (N=4)
module tb_fft_sdf_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        pipe_en;
  logic        in_zero;
  logic [3:0]  mux_sel;
  logic [15:0] w_idx;
  logic        out_valid;
  logic        out_first;
  logic        busy;
`ifdef FFT_SEQ_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  // Per-cycle expectation vectors: bit i (or nibble i for mx) belongs to cycle i.
  logic [31:0]  iv, pe, ov, of, iz, wi, bz, ir;
  logic [127:0] mx;

  fft_sdf_seq_ctrl #(.LOG2N(2), .MUXC_W(2), .WIDX_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pipe_en   (pipe_en),
    .in_zero   (in_zero),
    .mux_sel   (mux_sel),
    .w_idx     (w_idx),
    .out_valid (out_valid),
    .out_first (out_first),
`ifdef FFT_SEQ_FRAME_CNT_EN
    .frame_cnt (frame_cnt),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run_vec(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      in_valid = iv[i];
      #1;
      check($sformatf("%s[%0d] pipe_en", tag, i),   {31'd0, pipe_en},   {31'd0, pe[i]});
      check($sformatf("%s[%0d] out_valid", tag, i), {31'd0, out_valid}, {31'd0, ov[i]});
      check($sformatf("%s[%0d] out_first", tag, i), {31'd0, out_first}, {31'd0, of[i]});
      check($sformatf("%s[%0d] in_zero", tag, i),   {31'd0, in_zero},   {31'd0, iz[i]});
      check($sformatf("%s[%0d] in_ready", tag, i),  {31'd0, in_ready},  {31'd0, ir[i]});
      check($sformatf("%s[%0d] busy", tag, i),      {31'd0, busy},      {31'd0, bz[i]});
      check($sformatf("%s[%0d] mux_sel", tag, i),   {28'd0, mux_sel},   {28'd0, mx[4*i +: 4]});
      check($sformatf("%s[%0d] w_idx", tag, i),     {16'd0, w_idx},     {31'd0, wi[i]});
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst in_ready",  {31'd0, in_ready},  32'd0);
    check("rst pipe_en",   {31'd0, pipe_en},   32'd0);
    check("rst in_zero",   {31'd0, in_zero},   32'd0);
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst out_first", {31'd0, out_first}, 32'd0);
    check("rst busy",      {31'd0, busy},      32'd0);
    check("rst mux_sel",   {28'd0, mux_sel},   32'hA);
    check("rst w_idx",     {16'd0, w_idx},     32'd0);
`ifdef FFT_SEQ_FRAME_CNT_EN
    check("rst frame_cnt", {16'd0, frame_cnt}, 32'd0);
`endif
    #11;
    rst_n = 1'b1;

    // One frame, then drain: bins at cnt 3 (RUN) and 0,1,2 (DRAIN).
    iv = 32'h0000_000F; pe = 32'h0000_00EF; ov = 32'h0000_00E8; of = 32'h0000_0008;
    iz = 32'h0000_00E0; wi = 32'h0000_0008; bz = 32'h0000_00FE; ir = 32'h0000_011F;
    mx = 128'h0000_0000_0000_0000_0000_000A_4155_0415;
    run_vec("one_frame", 9);

    // Two frames back to back: no bubble between them, out_first at 3 and 7.
    iv = 32'h0000_00FF; pe = 32'h0000_0EFF; ov = 32'h0000_0EF8; of = 32'h0000_0088;
    iz = 32'h0000_0E00; wi = 32'h0000_0088; bz = 32'h0000_0FFE; ir = 32'h0000_11FF;
    mx = 128'h0000_0000_0000_0000_000A_4155_0415_0415;
    run_vec("two_frames", 13);

    // Three-cycle gap at cnt=1: everything frozen, same bin sequence afterwards.
    iv = 32'h0000_0071; pe = 32'h0000_0771; ov = 32'h0000_0740; of = 32'h0000_0040;
    iz = 32'h0000_0700; wi = 32'h0000_0040; bz = 32'h0000_07FE; ir = 32'h0000_08FF;
    mx = 128'h0000_0000_0000_0000_0000_A415_5041_1115;
    run_vec("gap", 12);

    // in_valid held through DRAIN: refused until IDLE, then taken as cnt=0.
    iv = 32'h0000_0FEF; pe = 32'h0000_EFEF; ov = 32'h0000_E8E8; of = 32'h0000_0808;
    iz = 32'h0000_E0E0; wi = 32'h0000_0808; bz = 32'h0000_FEFE; ir = 32'h0001_1F1F;
    mx = 128'h0000_0000_0000_000A_4155_0415_4155_0415;
    run_vec("drain_hold", 17);

`ifdef FFT_SEQ_FRAME_CNT_EN
    check("frame_cnt total", {16'd0, frame_cnt}, 32'd6);
`endif

    // Asynchronous reset while RUN at cnt=2 with a sample presented.
    tick();
    in_valid = 1'b1;
    tick();
    tick();
    check("pre_rst busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst pipe_en",   {31'd0, pipe_en},   32'd0);
    check("mid_rst mux_sel",   {28'd0, mux_sel},   32'hA);
    check("mid_rst out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst busy",      {31'd0, busy},      32'd0);
    check("mid_rst in_ready",  {31'd0, in_ready},  32'd0);
    check("mid_rst w_idx",     {16'd0, w_idx},     32'd0);
    in_valid = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
    tick();
    check("post_rst in_ready", {31'd0, in_ready}, 32'd1);
    check("post_rst busy",     {31'd0, busy},     32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
